mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Memory-stage access sequencer upstream of DataMemory. Accepts one load/store request per
//  transaction from the EX/MEM stage, drives DataMemory's combinational inData/addr/write/read
//  inputs glitch-free (settle address first, then strobe), captures load data, returns it to
//  writeback, and stalls the pipeline while busy.
// PARAMETERS
//  STROBE_CYCLES  1  cycles read/write code held non-zero (1..15)
//  ADDR_SHIFT     2  right shift byte address -> DataMemory word index
// PORTS
//  clk          in   1   rising-edge clock
//  rst          in   1   asynchronous, active-high reset
//  req_valid    in   1   request present from EX/MEM
//  req_ready    out  1   block idle, request accepted when req_valid&req_ready
//  req_we       in   1   1 = store, 0 = load
//  req_byte     in   1   1 = byte access, 0 = word access
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data (byte store uses [7:0])
//  req_rd       in   5   load destination register
//  mem_addr     out  32  to DataMemory addr
//  mem_inData   out  32  to DataMemory inData
//  mem_write    out  4   to DataMemory write: 0 none, 1 byte, 4'hF word
//  mem_read     out  4   to DataMemory read: 0 none, 1 byte, 4'hF word
//  mem_outData  in   32  from DataMemory outData
//  rsp_valid    out  1   one-cycle pulse, load data valid
//  rsp_data     out  32  load result
//  rsp_rd       out  5   load destination register
//  stall        out  1   = ~req_ready, freezes upstream pipeline
//  misalign     out  1   one-cycle pulse, misaligned word access trapped (macro only)
// BEHAVIOUR
//  Reset (async): state IDLE, req_ready=1, mem_write=mem_read=0, mem_addr=mem_inData=0,
//   rsp_valid=0, rsp_data=0, rsp_rd=0, misalign=0. Reset mid-transaction aborts it; strobes
//   drop immediately (async), no response issued.
//  FSM IDLE -> SETUP -> STROBE -> (RESP for loads | IDLE for stores).
//  IDLE: req_ready=1; on req_valid latch we/byte/addr/wdata/rd; -> SETUP.
//  SETUP (1 cycle): mem_addr = req_addr >> ADDR_SHIFT, mem_inData = wdata; strobes 0.
//  STROBE: mem_write (store) or mem_read (load) = 1 if byte else 4'hF; held STROBE_CYCLES
//   cycles via down-counter; address/data unchanged. Load: mem_outData sampled at the edge
//   ending the last strobe cycle. Never assert mem_read and mem_write together.
//  RESP (loads, 1 cycle): rsp_valid=1, rsp_data=captured word, rsp_rd=latched rd; strobes 0.
//  Stores return straight to IDLE after last strobe, strobes cleared same edge; no rsp_valid.
//  Latency: accept edge T; load rsp_valid during cycle T+2+STROBE_CYCLES; next accept no
//   earlier than edge T+3+STROBE_CYCLES (load) / T+2+STROBE_CYCLES (store).
//  req_valid while busy ignored (upstream frozen by stall); inputs sampled only in IDLE.
//  Byte load data passes through unmodified (DataMemory zero-extends).
//  req_addr bits below ADDR_SHIFT are discarded; mem_addr held at last value when idle.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: word access with req_addr[1:0]!=0 is accepted, then
//   IDLE -> IDLE with misalign pulsed 1 cycle after accept; no strobe, no rsp_valid.
//  Undefined: no check; misaligned word accesses proceed (low bits truncated); misalign
//   tied 0.
// STRUCTURE
//  Shared package mem_pkg: state enum (IDLE,SETUP,STROBE,RESP), MEM_NONE=4'h0,
//   MEM_BYTE=4'h1, MEM_WORD=4'hF, widths for addr/data/rd.
//  One sub-module natural: mem_strobe_timer (loadable down-counter, done flag).
// TESTING
//  Word store addr=0x10 data=0xDEADBEEF -> SETUP mem_addr=4, strobe mem_write=F 1 cycle, no rsp.
//  Word load addr=0x10 after above, rd=7 -> rsp_valid 3 cycles after accept, data=0xDEADBEEF, rd=7.
//  Byte store 0xAB @0x20 then byte load @0x20 -> mem_write=1/mem_read=1, rsp_data=0x000000AB.
//  STROBE_CYCLES=3 load -> mem_read=F held exactly 3 cycles, stall high 5 cycles total.
//  rst asserted mid-STROBE of a store -> mem_write=0 immediately, req_ready=1, no rsp_valid.
//  MEM_MISALIGN_TRAP_EN, word load @0x13 -> misalign pulse, strobes stay 0, no rsp_valid.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage access sequencer.
package mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int RD_W   = 5;

  localparam logic [3:0] MEM_NONE = 4'h0;
  localparam logic [3:0] MEM_BYTE = 4'h1;
  localparam logic [3:0] MEM_WORD = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    RESP
  } state_t;

  function automatic logic [3:0] access_code(input logic byte_acc);
    return byte_acc ? MEM_BYTE : MEM_WORD;
  endfunction

endpackage

// File: rtl/mem_strobe_timer.sv
// Loadable down-counter that measures how long the DataMemory strobe stays asserted.
module mem_strobe_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access sequencer: settles address/data, then strobes DataMemory, returns load data.
// Optional build macro MEM_MISALIGN_TRAP_EN traps misaligned word accesses instead of issuing them.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int STROBE_CYCLES = 1,
  parameter int ADDR_SHIFT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [RD_W-1:0]   req_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_inData,
  output logic [3:0]        mem_write,
  output logic [3:0]        mem_read,
  input  logic [DATA_W-1:0] mem_outData,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [RD_W-1:0]   rsp_rd,
  output logic              stall,
  output logic              misalign
);

  localparam int         CNT_W       = 4;
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

  state_t          state, next_state;
  logic            lat_we;
  logic            lat_byte;
  logic [RD_W-1:0] lat_rd;
  logic            accept;
  logic            trap;
  logic            timer_load;
  logic            timer_en;
  logic            timer_done;

  assign req_ready = (state == IDLE);
  assign stall     = ~req_ready;
  assign accept    = req_valid & req_ready;

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = accept & ~req_byte & (req_addr[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign <= 1'b0;
    end else begin
      misalign <= trap;
    end
  end
`else
  assign trap     = 1'b0;
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = trap ? IDLE : SETUP;
        end
      end
      SETUP: begin
        next_state = STROBE;
        timer_load = 1'b1;
      end
      STROBE: begin
        timer_en = 1'b1;
        if (timer_done) begin
          next_state = lat_we ? IDLE : RESP;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  mem_strobe_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (STROBE_LOAD),
    .en       (timer_en),
    .done     (timer_done)
  );

  // Address and store data are registered at accept so they are stable a full cycle before any strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr   <= '0;
      mem_inData <= '0;
      lat_we     <= 1'b0;
      lat_byte   <= 1'b0;
      lat_rd     <= '0;
    end else if (accept && !trap) begin
      mem_addr   <= req_addr >> ADDR_SHIFT;
      mem_inData <= req_wdata;
      lat_we     <= req_we;
      lat_byte   <= req_byte;
      lat_rd     <= req_rd;
    end
  end

  // Strobes are registered from next_state so DataMemory never sees a combinational glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_write <= MEM_NONE;
      mem_read  <= MEM_NONE;
      rsp_valid <= 1'b0;
    end else begin
      mem_write <= ((next_state == STROBE) && lat_we)  ? access_code(lat_byte) : MEM_NONE;
      mem_read  <= ((next_state == STROBE) && !lat_we) ? access_code(lat_byte) : MEM_NONE;
      rsp_valid <= (next_state == RESP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_data <= '0;
      rsp_rd   <= '0;
    end else if ((state == STROBE) && timer_done && !lat_we) begin
      rsp_data <= mem_outData;
      rsp_rd   <= lat_rd;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: vector table, hand-written corner sequences, random traffic vs. model.
module tb_mem_access_ctrl;

  localparam int S1 = 1;
  localparam int S3 = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        req_valid = 1'b0, req_we = 1'b0, req_byte = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        req_ready, rsp_valid, stall, misalign;
  logic [31:0] mem_addr, mem_inData, mem_outData, rsp_data;
  logic [3:0]  mem_write, mem_read;
  logic [4:0]  rsp_rd;

  logic        s3_req_valid = 1'b0, s3_req_we = 1'b0, s3_req_byte = 1'b0;
  logic [31:0] s3_req_addr = '0, s3_req_wdata = '0;
  logic [4:0]  s3_req_rd = '0;
  logic        s3_req_ready, s3_rsp_valid, s3_stall, s3_misalign;
  logic [31:0] s3_mem_addr, s3_mem_inData, s3_mem_outData, s3_rsp_data;
  logic [3:0]  s3_mem_write, s3_mem_read;
  logic [4:0]  s3_rsp_rd;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.STROBE_CYCLES(S1), .ADDR_SHIFT(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_addr(mem_addr), .mem_inData(mem_inData), .mem_write(mem_write), .mem_read(mem_read),
    .mem_outData(mem_outData), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
    .stall(stall), .misalign(misalign)
  );

  mem_access_ctrl #(.STROBE_CYCLES(S3), .ADDR_SHIFT(2)) dut3 (
    .clk(clk), .rst(rst), .req_valid(s3_req_valid), .req_ready(s3_req_ready), .req_we(s3_req_we),
    .req_byte(s3_req_byte), .req_addr(s3_req_addr), .req_wdata(s3_req_wdata), .req_rd(s3_req_rd),
    .mem_addr(s3_mem_addr), .mem_inData(s3_mem_inData), .mem_write(s3_mem_write),
    .mem_read(s3_mem_read), .mem_outData(s3_mem_outData), .rsp_valid(s3_rsp_valid),
    .rsp_data(s3_rsp_data), .rsp_rd(s3_rsp_rd), .stall(s3_stall), .misalign(s3_misalign)
  );

  // DataMemory stand-in: word-indexed, byte writes touch the low byte, byte reads zero-extend.
  logic [31:0] bmem [0:15];

  always @(posedge clk) begin
    if (mem_write == 4'hF) bmem[mem_addr[3:0]] <= mem_inData;
    else if (mem_write == 4'h1) bmem[mem_addr[3:0]][7:0] <= mem_inData[7:0];
  end

  always_comb begin
    mem_outData = 32'hBAD0_BAD0;
    if (mem_read == 4'hF) mem_outData = bmem[mem_addr[3:0]];
    else if (mem_read == 4'h1) mem_outData = {24'h0, bmem[mem_addr[3:0]][7:0]};
  end

  assign s3_mem_outData = (s3_mem_read != 4'h0) ? 32'h1234_5678 : 32'hBAD0_BAD0;

  logic [31:0] ref_mem [0:15];

  typedef struct {
    int          busy;
    int          stall_n;
    int          strobe_n;
    logic [3:0]  wcode;
    logic [3:0]  rcode;
    logic        both;
    logic        moved;
    logic [31:0] setup_addr;
    logic [31:0] setup_data;
    int          rsp_n;
    int          rsp_k;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    int          mis_k;
  } obs_t;

  typedef struct {
    logic        we;
    logic        byt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_wcode;
    logic [3:0]  exp_rcode;
    logic        exp_rsp;
    logic [31:0] exp_data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic ref_apply(input logic byt, input logic [31:0] addr, input logic [31:0] wdata);
    if (byt) ref_mem[addr[5:2]][7:0] = wdata[7:0];
    else ref_mem[addr[5:2]] = wdata;
  endtask

  task automatic run_txn(input logic we, input logic byt, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd, output obs_t o);
    logic [31:0] strobe_addr;
    int n;
    o.busy = -1; o.stall_n = 0; o.strobe_n = 0; o.wcode = 4'h0; o.rcode = 4'h0;
    o.both = 1'b0; o.moved = 1'b0; o.setup_addr = '0; o.setup_data = '0;
    o.rsp_n = 0; o.rsp_k = -1; o.rsp_data = '0; o.rsp_rd = '0; o.mis_k = -1;
    strobe_addr = '0;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_we = we; req_byte = byt; req_addr = addr; req_wdata = wdata; req_rd = rd;
    @(posedge clk);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0;
        o.setup_addr = mem_addr;
        o.setup_data = mem_inData;
      end
      if (mem_write != 4'h0 && mem_read != 4'h0) o.both = 1'b1;
      if (mem_write != 4'h0 || mem_read != 4'h0) begin
        if (o.strobe_n == 0) strobe_addr = mem_addr;
        else if (mem_addr != strobe_addr) o.moved = 1'b1;
        o.strobe_n++;
        if (mem_write != 4'h0) o.wcode = mem_write;
        if (mem_read != 4'h0) o.rcode = mem_read;
      end
      if (rsp_valid) begin
        o.rsp_n++;
        o.rsp_k = k;
        o.rsp_data = rsp_data;
        o.rsp_rd = rsp_rd;
      end
      if (misalign) o.mis_k = k;
      if (stall) o.stall_n++;
      if (req_ready) begin
        o.busy = k - 1;
        break;
      end
    end
  endtask

  task automatic model_check(input string tag, input logic we, input logic byt,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [4:0] rd, input obs_t o);
    logic        trapped;
    logic [3:0]  code;
    logic [31:0] exp;
    trapped = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    trapped = !byt && (addr[1:0] != 2'b00);
`endif
    code = byt ? 4'h1 : 4'hF;
    if (trapped) begin
      chk({tag, " trap busy"}, o.busy, 0);
      chk({tag, " trap strobes"}, o.strobe_n, 0);
      chk({tag, " trap rsp"}, o.rsp_n, 0);
      chk({tag, " trap misalign cycle"}, o.mis_k, 1);
    end else begin
      chk({tag, " setup addr"}, o.setup_addr, addr >> 2);
      chk({tag, " strobe cycles"}, o.strobe_n, S1);
      chk({tag, " rd&wr overlap"}, {31'h0, o.both}, 0);
      chk({tag, " addr moved"}, {31'h0, o.moved}, 0);
      chk({tag, " misalign"}, o.mis_k, -1);
      chk({tag, " stall cycles"}, o.stall_n, o.busy);
      if (we) begin
        chk({tag, " codes"}, {24'h0, o.wcode, o.rcode}, {24'h0, code, 4'h0});
        chk({tag, " setup data"}, o.setup_data, wdata);
        chk({tag, " store rsp"}, o.rsp_n, 0);
        chk({tag, " store busy"}, o.busy, 1 + S1);
        ref_apply(byt, addr, wdata);
      end else begin
        exp = byt ? {24'h0, ref_mem[addr[5:2]][7:0]} : ref_mem[addr[5:2]];
        chk({tag, " codes"}, {24'h0, o.wcode, o.rcode}, {24'h0, 4'h0, code});
        chk({tag, " load rsp count"}, o.rsp_n, 1);
        chk({tag, " load rsp cycle"}, o.rsp_k, 2 + S1);
        chk({tag, " load data"}, o.rsp_data, exp);
        chk({tag, " load rd"}, {27'h0, o.rsp_rd}, {27'h0, rd});
        chk({tag, " load busy"}, o.busy, 2 + S1);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [8];
    obs_t        o;
    logic        we, byt;
    logic [31:0] addr, wdata;
    logic [4:0]  rd;
    int          cnt_a, cnt_b, cnt_c, kr;
    logic [31:0] d3;

    for (int i = 0; i < 16; i++) ref_mem[i] = '0;

    //             we    byt   addr    wdata          rd    maddr  wcode rcode rsp   data
    tbl[0] = '{1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0,  32'h4, 4'hF, 4'h0, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 1'b0, 32'h10, 32'h0,        5'd7,  32'h4, 4'h0, 4'hF, 1'b1, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 1'b1, 32'h20, 32'h123456AB, 5'd0,  32'h8, 4'h1, 4'h0, 1'b0, 32'h0};
    tbl[3] = '{1'b0, 1'b1, 32'h20, 32'h0,        5'd3,  32'h8, 4'h0, 4'h1, 1'b1, 32'h000000AB};
    tbl[4] = '{1'b1, 1'b0, 32'h24, 32'hCAFEF00D, 5'd0,  32'h9, 4'hF, 4'h0, 1'b0, 32'h0};
    tbl[5] = '{1'b1, 1'b1, 32'h27, 32'h00000011, 5'd0,  32'h9, 4'h1, 4'h0, 1'b0, 32'h0};
    tbl[6] = '{1'b0, 1'b0, 32'h24, 32'h0,        5'd31, 32'h9, 4'h0, 4'hF, 1'b1, 32'hCAFEF011};
    tbl[7] = '{1'b0, 1'b1, 32'h25, 32'h0,        5'd1,  32'h9, 4'h0, 4'h1, 1'b1, 32'h00000011};

    // Reset state, while held and after release.
    #1 rst = 1'b1;
    #1;
    chk("reset req_ready", {31'h0, req_ready}, 1);
    chk("reset stall", {31'h0, stall}, 0);
    chk("reset strobes", {24'h0, mem_write, mem_read}, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_inData", mem_inData, 0);
    chk("reset rsp", {26'h0, rsp_valid, rsp_rd}, 0);
    chk("reset rsp_data", rsp_data, 0);
    chk("reset misalign", {31'h0, misalign}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle after reset ready", {31'h0, req_ready}, 1);
    chk("idle after reset rsp_valid", {31'h0, rsp_valid}, 0);

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i].we, tbl[i].byt, tbl[i].addr, tbl[i].wdata, tbl[i].rd, o);
      chk($sformatf("vec%0d setup addr", i), o.setup_addr, tbl[i].exp_maddr);
      chk($sformatf("vec%0d codes", i), {24'h0, o.wcode, o.rcode}, {24'h0, tbl[i].exp_wcode, tbl[i].exp_rcode});
      chk($sformatf("vec%0d strobe cycles", i), o.strobe_n, S1);
      chk($sformatf("vec%0d rsp count", i), o.rsp_n, tbl[i].exp_rsp ? 1 : 0);
      chk($sformatf("vec%0d busy", i), o.busy, tbl[i].exp_rsp ? 3 : 2);
      if (tbl[i].exp_rsp) begin
        chk($sformatf("vec%0d rsp cycle", i), o.rsp_k, 3);
        chk($sformatf("vec%0d rsp data", i), o.rsp_data, tbl[i].exp_data);
        chk($sformatf("vec%0d rsp rd", i), {27'h0, o.rsp_rd}, {27'h0, tbl[i].rd});
      end else begin
        ref_apply(tbl[i].byt, tbl[i].addr, tbl[i].wdata);
      end
    end

    // Longer strobe: S=3 load holds mem_read for 3 cycles, stall for 5.
    @(negedge clk);
    s3_req_valid = 1'b1; s3_req_we = 1'b0; s3_req_byte = 1'b0; s3_req_addr = 32'h40; s3_req_rd = 5'd12;
    @(posedge clk);
    cnt_a = 0; cnt_b = 0; cnt_c = 0; kr = -1; d3 = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        s3_req_valid = 1'b0;
        chk("s3 setup addr", s3_mem_addr, 32'h10);
        chk("s3 setup data", s3_mem_inData, 32'h0);
      end
      if (s3_mem_read == 4'hF) cnt_a++;
      if (s3_mem_write != 4'h0) cnt_c++;
      if (s3_stall) cnt_b++;
      if (s3_misalign) cnt_c++;
      if (s3_rsp_valid) begin
        kr = k;
        d3 = s3_rsp_data;
        chk("s3 rsp rd", {27'h0, s3_rsp_rd}, 32'd12);
      end
      if (s3_req_ready) break;
    end
    chk("s3 read strobe cycles", cnt_a, 3);
    chk("s3 stall cycles", cnt_b, 5);
    chk("s3 no write/misalign", cnt_c, 0);
    chk("s3 rsp cycle", kr, 5);
    chk("s3 rsp data", d3, 32'h1234_5678);

    // Fill every word so the model knows all of memory, then random traffic.
    for (int i = 0; i < 16; i++) begin
      wdata = $urandom;
      run_txn(1'b1, 1'b0, 32'(i * 4), wdata, 5'd0, o);
      model_check($sformatf("init%0d", i), 1'b1, 1'b0, 32'(i * 4), wdata, 5'd0, o);
    end
    for (int i = 0; i < 150; i++) begin
      we    = 1'($urandom_range(0, 1));
      byt   = 1'($urandom_range(0, 1));
      addr  = ($urandom & 32'hFFFF_FFC0) | 32'($urandom_range(0, 63));
      wdata = $urandom;
      rd    = 5'($urandom_range(0, 31));
      run_txn(we, byt, addr, wdata, rd, o);
      model_check($sformatf("rnd%0d", i), we, byt, addr, wdata, rd, o);
    end

    // Word load at 0x13: trapped with the macro, low bits truncated without it.
    run_txn(1'b0, 1'b0, 32'h13, 32'h0, 5'd5, o);
    model_check("misaligned load", 1'b0, 1'b0, 32'h13, 32'h0, 5'd5, o);

    // Reset in the middle of a store strobe aborts it with no write and no response.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0; req_addr = 32'h30; req_wdata = 32'h5A5A5A5A; req_rd = 5'd0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort strobe before reset", {28'h0, mem_write}, 32'hF);
    #2 rst = 1'b1;
    #1;
    chk("abort strobes dropped", {24'h0, mem_write, mem_read}, 0);
    chk("abort req_ready", {31'h0, req_ready}, 1);
    chk("abort mem_addr", mem_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    cnt_a = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid || mem_write != 4'h0) cnt_a++;
    end
    chk("abort no activity", cnt_a, 0);
    run_txn(1'b0, 1'b0, 32'h30, 32'h0, 5'd9, o);
    model_check("after abort load", 1'b0, 1'b0, 32'h30, 32'h0, 5'd9, o);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
